// File: rtl/arbiter8_rr_if.sv
// arbiter8_rr_if -- request/grant bundle between eight requesters and the
// round-robin arbiter.
//   req     : level request per requester (bit i = requester i)
//   gnt     : one-hot grant or zero
//   gnt_id  : index of the current owner, 0 while idle
//   busy    : a grant is active
//   any_req : OR of all request bits (combinational)
// Modports: master = requester side, slave = arbiter side.
interface arbiter8_rr_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       any_req;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  any_req
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output any_req
  );
endinterface

// File: rtl/arbiter8_rr.sv
// arbiter8_rr -- eight-way round-robin arbiter for one shared resource.
// A requester holds its level request while it needs the resource; the
// grant is held until the owner drops its request or MAX_HOLD consecutive
// cycles elapse, after which priority rotates past the owner. Every release
// is followed by at least one idle cycle.
// Parameters:
//   MAX_HOLD : max consecutive grant cycles per owner (0..255, 0 = no limit)
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : arbiter8_rr_if.slave (req in; gnt, gnt_id, busy, any_req out)
module arbiter8_rr #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic          clock,
  input  logic          reset_n,
  arbiter8_rr_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit         LIMIT_EN  = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state_q;
  logic [2:0] ptr_q;
  logic [2:0] owner_q;
  logic [7:0] hold_cnt_q;
  logic [7:0] gnt_q;
  logic [2:0] gnt_id_q;
  logic       busy_q;

  logic       any_req;
  logic [2:0] winner_d;
  logic [2:0] scan_idx;
  logic       found;
  logic       rel;

  assign any_req     = |bus.req;
  assign bus.any_req = any_req;
  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;

  // First set request scanning ptr, ptr+1, ... ptr+7; the 3-bit add wraps mod 8.
  always_comb begin
    winner_d = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      scan_idx = ptr_q + 3'(i);
      if (!found && bus.req[scan_idx]) begin
        winner_d = scan_idx;
        found    = 1'b1;
      end
    end
  end

  // Owner leaves when it drops its request or reaches the last allowed cycle.
  always_comb begin
    rel = !bus.req[owner_q] || (LIMIT_EN && (hold_cnt_q == HOLD_LAST));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q    <= GRANT;
            owner_q    <= winner_d;
            gnt_q      <= 8'b1 << winner_d;
            gnt_id_q   <= winner_d;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            // hold_cnt is left as-is; it is re-zeroed on the next grant.
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
            ptr_q    <= owner_q + 3'd1;
          end else if (hold_cnt_q != '1) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter8_rr.sv
// tb_arbiter8_rr -- directed bench for arbiter8_rr. Four instances cover the
// different hold limits (15, 4, 3, 0); all share clock and reset.
module tb_arbiter8_rr;

  logic clock;
  logic reset_n;

  int unsigned passed;
  int unsigned total;

  arbiter8_rr_if ifa ();
  arbiter8_rr_if ifb ();
  arbiter8_rr_if ifc ();
  arbiter8_rr_if ifd ();

  arbiter8_rr #(.MAX_HOLD(15)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ifa));
  arbiter8_rr #(.MAX_HOLD(4))  dut_b (.clock(clock), .reset_n(reset_n), .bus(ifb));
  arbiter8_rr #(.MAX_HOLD(3))  dut_c (.clock(clock), .reset_n(reset_n), .bus(ifc));
  arbiter8_rr #(.MAX_HOLD(0))  dut_d (.clock(clock), .reset_n(reset_n), .bus(ifd));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] exp_g;
    passed  = 0;
    total   = 0;
    reset_n = 1'b0;
    ifa.req = 8'hFF;
    ifb.req = 8'h00;
    ifc.req = 8'h00;
    ifd.req = 8'h00;

    // Reset held with all requests high
    tick();
    tick();
    chk("rst_gnt",    ifa.gnt, 8'h00);
    chk("rst_busy",   {7'd0, ifa.busy}, 8'h00);
    chk("rst_gnt_id", {5'd0, ifa.gnt_id}, 8'h00);
    chk("any_req_ff", {7'd0, ifa.any_req}, 8'h01);
    reset_n = 1'b1;
    tick();
    chk("post_rst_gnt",    ifa.gnt, 8'h01);
    chk("post_rst_gnt_id", {5'd0, ifa.gnt_id}, 8'h00);
    chk("post_rst_busy",   {7'd0, ifa.busy}, 8'h01);
    ifa.req = 8'h00;
    #1;
    chk("any_req_0", {7'd0, ifa.any_req}, 8'h00);
    tick();
    chk("release_0", ifa.gnt, 8'h00);
    tick();                                   // ptr now 1

    // Voluntary release by requester 7 and pointer wrap
    ifa.req = 8'h80;
    #1;
    chk("any_req_80", {7'd0, ifa.any_req}, 8'h01);
    tick();
    chk("gnt7",    ifa.gnt, 8'h80);
    chk("gnt7_id", {5'd0, ifa.gnt_id}, 8'h07);
    tick();
    chk("gnt7_hold2", ifa.gnt, 8'h80);
    tick();
    chk("gnt7_hold3", ifa.gnt, 8'h80);
    ifa.req = 8'h00;
    tick();                                   // edge N: release
    chk("gnt7_rel", ifa.gnt, 8'h00);
    chk("gnt7_rel_busy", {7'd0, ifa.busy}, 8'h00);
    ifa.req = 8'h81;
    tick();                                   // edge N+1: wrap to 0
    chk("wrap_gnt",    ifa.gnt, 8'h01);
    chk("wrap_gnt_id", {5'd0, ifa.gnt_id}, 8'h00);
    ifa.req = 8'h00;
    tick();
    chk("wrap_rel", ifa.gnt, 8'h00);
    tick();                                   // ptr now 1

    // Rotation, MAX_HOLD=4, full load
    ifb.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_g = 8'h01 << (k % 8);
      for (int c = 0; c < 4; c++) begin
        tick();
        chk("rot_gnt", ifb.gnt, exp_g);
        chk("rot_id", {5'd0, ifb.gnt_id}, 8'(k % 8));
      end
      tick();
      chk("rot_gap", ifb.gnt, 8'h00);
    end
    ifb.req = 8'h00;
    tick();

    // Lone requester timeout, MAX_HOLD=3
    ifc.req = 8'h04;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        chk("lone_gnt", ifc.gnt, 8'h04);
      end
      tick();
      chk("lone_gap", ifc.gnt, 8'h00);
    end
    ifc.req = 8'h00;
    tick();

    // No hold limit, 300 cycles of one requester
    ifd.req = 8'h02;
    for (int c = 0; c < 300; c++) begin
      tick();
      chk("nolimit_gnt", ifd.gnt, 8'h02);
    end
    chk("nolimit_sat", dut_d.hold_cnt_q, 8'hFF);
    ifd.req = 8'h00;
    tick();
    chk("nolimit_rel", ifd.gnt, 8'h00);
    tick();

    // Async reset in the middle of a grant to requester 4 (ptr was 1)
    ifa.req = 8'h10;
    tick();
    chk("pre_ar_gnt", ifa.gnt, 8'h10);
    tick();
    chk("pre_ar_hold", ifa.gnt, 8'h10);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar_gnt",    ifa.gnt, 8'h00);
    chk("ar_busy",   {7'd0, ifa.busy}, 8'h00);
    chk("ar_gnt_id", {5'd0, ifa.gnt_id}, 8'h00);
    #1;
    reset_n = 1'b1;
    ifa.req = 8'h30;
    tick();
    chk("post_ar_gnt",    ifa.gnt, 8'h10);
    chk("post_ar_gnt_id", {5'd0, ifa.gnt_id}, 8'h04);
    ifa.req = 8'h00;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/arbiter8_rr.md
# arbiter8_rr

Round-robin arbiter that shares one downstream resource among eight requesters. Requesters hold a level request for as long as they need the resource. The block grants exactly one of them at a time, holds the grant until the owner drops its request or a hold limit expires, and then rotates priority. It sits between the eight requester ports and the shared resource. The `any_req` output is the 8-way OR reduction of the requests, the same function as the gate-level `Or8Way`.

## Interface
Parameters:
- `MAX_HOLD`, default 15: maximum consecutive cycles one owner may hold the grant. Range 0–255; 0 disables the limit.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in 8: level request per requester; bit i belongs to requester i.
- `gnt` out 8: one-hot grant, or all zero; registered.
- `gnt_id` out 3: index of the current owner; valid only while `busy`=1, and 0 otherwise.
- `busy` out 1: 1 while any grant is active; registered.
- `any_req` out 1: OR of all `req` bits; combinational, no register.

## Operation
- **State.**
  - FSM: `IDLE` or `GRANT`.
  - `ptr[2:0]`: search start for the next grant.
  - `owner[2:0]`: current owner.
  - `hold_cnt[7:0]`: cycles the owner has held the grant.
- **Reset values.**
  - `state`=`IDLE`, `ptr`=0, `owner`=0, `hold_cnt`=0.
  - `gnt`=8'h00, `gnt_id`=0, `busy`=0.
- **Arbitration.** The winner is the first set bit of `req`, scanning `ptr`, `ptr`+1, … , `ptr`+7, with indices taken mod 8.
- **`IDLE`.**
  - If `any_req`=1: latch the winner into `owner`, set `gnt[winner]`, `busy`=1, `hold_cnt`=0, and go to `GRANT`.
  - Otherwise stay in `IDLE` with outputs at zero.
- **`GRANT`.** The owner releases in a cycle where either condition holds:
  - `req[owner]`=0, or
  - `MAX_HOLD`≠0 and `hold_cnt`=`MAX_HOLD`−1.
- **On release:**
  - go to `IDLE`;
  - clear `gnt` and `busy`;
  - set `ptr` = `owner`+1 (mod 8; owner 7 wraps to 0);
  - leave `hold_cnt` unchanged.
- **Otherwise in `GRANT`:** `hold_cnt` increments and saturates at 255. Requests from other requesters are ignored; there is no preemption.
- **`gnt_id`** is `owner` while `busy`=1, and 0 otherwise.
- **Timeout:**
  - The owner is forced out even if it still requests.
  - Because `ptr` has moved past it, any other pending requester wins next.
  - If no other requester is pending, the same owner is re-granted after the gap cycle.
- **Invariants:**
  - `gnt` is never more than one-hot.
  - `gnt` is nonzero if and only if `busy`=1.
  - A requester whose `req` is low is never newly granted.
- **Reset mid-grant:** `reset_n` low clears all state and outputs immediately, without waiting for a clock. After release, arbitration restarts from `ptr`=0.

## Timing
- **Grant latency.** `req` rising, sampled at edge N while the FSM is in `IDLE`, gives `gnt` high after edge N. The minimum latency is 1 cycle.
- **Release latency.** `req[owner]` low, sampled at edge N, gives `gnt` low after edge N.
- **Gap cycle.** Every release is followed by at least one cycle with `gnt`=0 (`IDLE`). The next grant appears after edge N+1. Consecutive owners therefore never overlap or abut.
- **Hold limit.** With `MAX_HOLD`=M≥1 and a continuously requesting owner, `gnt` is high for exactly M cycles, then low for exactly 1 cycle.
- **`MAX_HOLD`=1.** Every grant lasts 1 cycle. Under full load, grants alternate with single gap cycles and rotate 0,1,…,7,0.
- **Same-edge request.** A requester that raises `req` in the same cycle its competitor is granted is not considered until the next `IDLE` cycle.
- **`any_req`** follows `req` within the same cycle.

## Test plan
- **Reset.** Hold `reset_n`=0 with `req`=8'hFF, then release it. During reset, `gnt`=0, `busy`=0, `gnt_id`=0. On the first edge after release, `gnt`=8'h01 and `gnt_id`=0.
- **Rotation.** Set `req`=8'hFF with `MAX_HOLD`=4. Grants go to 0,1,2,…,7,0 in that order, each lasting exactly 4 cycles and separated by 1 cycle of `gnt`=0.
- **Voluntary release and wrap.** Assert `req`=8'h80 until granted, hold 3 cycles, then drop it. Next assert `req`=8'h81. The grant goes to requester 0, because `ptr` wrapped to 0, and `gnt`=8'h01 appears exactly 2 edges after `req[7]` fell.
- **Timeout with a lone requester.** Set `req`=8'h04 continuously with `MAX_HOLD`=3. The output repeats 3 cycles of `gnt`=8'h04, then 1 cycle of 0.
- **`MAX_HOLD`=0.** Set `req`=8'h02 for 300 cycles. `gnt` stays at 8'h02 throughout, and `hold_cnt` saturates at 255 without wrapping.
- **Async reset mid-grant.** While `gnt`=8'h10, pulse `reset_n` low between clock edges. `gnt` and `busy` go to 0 before the next edge. On re-arbitration with `req`=8'h30, requester 4 wins, since the search starts from `ptr`=0.
